// File: rtl/mac_io_glue_if.sv
// mac_io_glue_if
//  CPU read-side bus between the 68000 data path and the peripheral glue.
//  Carries the peripheral chip selects, the peripheral and memory read
//  data, the memory bus ownership/valid qualifiers and the muxed CPU read
//  data.
//  Modports:
//   master : CPU/peripheral side; drives selects, read data, qualifiers;
//            receives cpuDataOut.
//   slave  : the glue; receives selects, read data, qualifiers;
//            drives cpuDataOut.
interface mac_io_glue_if;
    logic        selectIWM;
    logic        selectVIA;
    logic        selectSCC;
    logic        selectSCSI;
    logic [15:0] iwmData;
    logic [7:0]  viaData;
    logic [7:0]  sccData;
    logic [7:0]  scsiData;
    logic [15:0] memoryDataIn;
    logic        cpuBusControl;
    logic        memoryLatch;
    logic [15:0] cpuDataOut;

    modport master (
        output selectIWM, selectVIA, selectSCC, selectSCSI,
        output iwmData, viaData, sccData, scsiData,
        output memoryDataIn, cpuBusControl, memoryLatch,
        input  cpuDataOut
    );

    modport slave (
        input  selectIWM, selectVIA, selectSCC, selectSCSI,
        input  iwmData, viaData, sccData, scsiData,
        input  memoryDataIn, cpuBusControl, memoryLatch,
        output cpuDataOut
    );
endinterface

// File: rtl/mac_io_glue.sv
// mac_io_glue
//  Peripheral glue for the Mac Plus data controller: CPU power-on reset,
//  68000 IPL encoding, CPU read-data mux with memory hold register, sound
//  sample/volume path, 1 Hz vblank tick and the VIA CB1/CB2 keyboard link.
//  Build option: define SND_VOLUME_EN for 3-bit volume summation; without
//  it the audio output is the x4 term only (mute still applies).
//  Ports:
//   clk32, _systemReset           clock, async active-low reset
//   clk8_en_p, clk8_en_n          8 MHz phase enables
//   _cpuReset                     CPU reset (low until reset counter expires)
//   _viaIrq, _sccIrq, _cpuIPL     interrupt inputs and IPL outputs
//   bus (mac_io_glue_if.slave)    CPU read bus: selects, read data, cpuDataOut
//   loadSound, snd_vol, snd_ena   sound fetch strobe, volume bits, mute
//   audioOut                      signed 11-bit audio
//   _vblank, onesec               vblank input, one-second flag
//   cb2_o, cb2_t, kbdclk, kbddata_o   VIA CB1/CB2 serial link
//   kbd_in_*, kbd_out_*           bytes to / from the keyboard model
module mac_io_glue #(
    parameter logic [19:0] RESET_CYCLES = 20'hFFFFF,
    parameter int          KBD_HALF     = 1300,
    parameter int          VBL_PER_SEC  = 60
) (
    input  logic         clk32,
    input  logic         _systemReset,
    input  logic         clk8_en_p,
    input  logic         clk8_en_n,
    output logic         _cpuReset,
    input  logic         _viaIrq,
    input  logic         _sccIrq,
    output logic [2:0]   _cpuIPL,
    mac_io_glue_if.slave bus,
    input  logic         loadSound,
    input  logic [2:0]   snd_vol,
    input  logic         snd_ena,
    output logic [10:0]  audioOut,
    input  logic         _vblank,
    output logic         onesec,
    input  logic         cb2_o,
    input  logic         cb2_t,
    output logic         kbdclk,
    output logic         kbddata_o,
    input  logic [7:0]   kbd_in_data,
    input  logic         kbd_in_strobe,
    output logic [7:0]   kbd_out_data,
    output logic         kbd_out_strobe
);

    // Keyboard link states
    //  state      | meaning
    //  KS_IDLE    | clock stopped, waiting for the Mac to pull CB2 low
    //  KS_TX      | clocking a byte in from the Mac (CB2 -> kbd_out_data)
    //  KS_WAIT_RX | byte received, clock stopped until line released and key queued
    //  KS_RX      | clocking kbd_to_mac out to the Mac on kbddata_o
    typedef enum logic [1:0] {KS_IDLE, KS_TX, KS_WAIT_RX, KS_RX} kbd_state_t;

    localparam int              KW         = (KBD_HALF > 0) ? $clog2(KBD_HALF + 1) : 1;
    localparam logic [KW-1:0]   KBD_HALF_C = KW'(KBD_HALF);
    localparam logic [7:0]      VBL_LAST   = 8'(VBL_PER_SEC - 1);

    // ---------------- CPU reset counter ----------------
    logic [19:0] rst_cnt_q, rst_cnt_d;
    logic        cpu_run;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (clk8_en_p && (rst_cnt_q != '0))
            rst_cnt_d = rst_cnt_q - 20'd1;
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) rst_cnt_q <= RESET_CYCLES;
        else               rst_cnt_q <= rst_cnt_d;
    end

    assign _cpuReset = (rst_cnt_q == '0);
    assign cpu_run   = _cpuReset;

    // ---------------- Interrupts ----------------
    always_comb begin
        if (!_viaIrq)      _cpuIPL = 3'b110;
        else if (!_sccIrq) _cpuIPL = 3'b101;
        else               _cpuIPL = 3'b111;
    end

    // ---------------- Read mux ----------------
    logic [15:0] hold_q;
    logic        no_sel;
    logic        mem_take;

    assign no_sel   = ~(bus.selectIWM | bus.selectVIA | bus.selectSCC | bus.selectSCSI);
    assign mem_take = no_sel & bus.cpuBusControl & bus.memoryLatch;

    always_comb begin
        if (bus.selectIWM)       bus.cpuDataOut = bus.iwmData;
        else if (bus.selectVIA)  bus.cpuDataOut = {bus.viaData, 8'hEF};
        else if (bus.selectSCC)  bus.cpuDataOut = {bus.sccData, 8'hEF};
        else if (bus.selectSCSI) bus.cpuDataOut = {bus.scsiData, 8'hEF};
        else if (mem_take)       bus.cpuDataOut = bus.memoryDataIn;
        else                     bus.cpuDataOut = hold_q;
    end

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset)  hold_q <= '0;
        else if (!cpu_run)  hold_q <= '0;
        else if (mem_take)  hold_q <= bus.memoryDataIn;
    end

    // ---------------- Audio ----------------
    logic              snd_pend_q;
    logic signed [7:0] snd_latch_q;
    logic signed [10:0] snd_x1, snd_x2, snd_x4;

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            snd_pend_q  <= 1'b0;
            snd_latch_q <= '0;
        end else if (!cpu_run) begin
            snd_pend_q  <= 1'b0;
            snd_latch_q <= '0;
        end else begin
            if (clk8_en_n)
                snd_pend_q <= loadSound;
            if (clk8_en_p && snd_pend_q) begin
                snd_pend_q <= 1'b0;
                // unsigned sample minus 128 is just the MSB flipped
                snd_latch_q <= snd_ena ? 8'sd0 : signed'(bus.memoryDataIn[15:8] ^ 8'h80);
            end
        end
    end

    assign snd_x1 = {{3{snd_latch_q[7]}}, snd_latch_q};
    assign snd_x2 = {{2{snd_latch_q[7]}}, snd_latch_q, 1'b0};
    assign snd_x4 = {snd_latch_q[7], snd_latch_q, 2'b00};

`ifdef SND_VOLUME_EN
    always_comb begin
        audioOut = '0;
        if (snd_vol[0]) audioOut = audioOut + snd_x1;
        if (snd_vol[1]) audioOut = audioOut + snd_x2;
        if (snd_vol[2]) audioOut = audioOut + snd_x4;
    end
`else
    logic snd_unused;
    assign snd_unused = ^{snd_vol, snd_x1, snd_x2};
    assign audioOut   = snd_x4;
`endif

    // ---------------- One-second tick ----------------
    logic       vbl_q;
    logic [7:0] vbl_cnt_q;

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            vbl_q     <= 1'b1;
            vbl_cnt_q <= '0;
        end else if (!cpu_run) begin
            vbl_q     <= 1'b1;
            vbl_cnt_q <= '0;
        end else if (clk8_en_n) begin
            vbl_q <= _vblank;
            if (vbl_q && !_vblank)
                vbl_cnt_q <= (vbl_cnt_q == VBL_LAST) ? 8'd0 : vbl_cnt_q + 8'd1;
        end
    end

    assign onesec = (vbl_cnt_q == VBL_LAST);

    // ---------------- Keyboard link ----------------
    kbd_state_t    kbd_state_q;
    logic [KW-1:0] kbd_cnt_q;
    logic          kbdclk_q;
    logic          kbddata_q;
    logic          data_valid_q;
    logic [2:0]    kbd_bitcnt_q;
    logic [7:0]    kbd_to_mac_q;
    logic [7:0]    kbd_out_data_q;
    logic          kbd_out_strobe_q;
    logic          kbddat_i;
    logic          clk_run;

    // CB2 reads high when the VIA is not driving it
    assign kbddat_i = ~cb2_t | cb2_o;
    assign clk_run  = (kbd_state_q == KS_TX) || (kbd_state_q == KS_RX);

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset || !cpu_run) begin
            kbd_state_q      <= KS_IDLE;
            kbd_cnt_q        <= '0;
            kbdclk_q         <= 1'b1;
            kbddata_q        <= 1'b1;
            data_valid_q     <= 1'b0;
            kbd_bitcnt_q     <= '0;
            kbd_to_mac_q     <= '0;
            kbd_out_data_q   <= '0;
            kbd_out_strobe_q <= 1'b0;
        end else if (clk8_en_p) begin
            kbd_out_strobe_q <= 1'b0;
            if (clk_run) begin
                if (kbd_cnt_q == KBD_HALF_C) begin
                    kbd_cnt_q <= '0;
                    kbdclk_q  <= ~kbdclk_q;
                    if (kbdclk_q) begin
                        if (kbd_state_q == KS_TX)
                            kbd_out_data_q <= {kbd_out_data_q[6:0], kbddat_i};
                        else
                            // ~bitcnt == 7 - bitcnt: MSB first
                            kbddata_q <= kbd_to_mac_q[~kbd_bitcnt_q];
                    end else begin
                        kbd_bitcnt_q <= kbd_bitcnt_q + 3'd1;
                        if (kbd_bitcnt_q == 3'd7) begin
                            if (kbd_state_q == KS_TX) begin
                                kbd_out_strobe_q <= 1'b1;
                                kbd_state_q      <= KS_WAIT_RX;
                            end else begin
                                kbd_state_q  <= KS_IDLE;
                                data_valid_q <= 1'b0;
                            end
                        end
                    end
                end else begin
                    kbd_cnt_q <= kbd_cnt_q + KW'(1);
                end
            end else begin
                kbd_cnt_q <= '0;
                kbdclk_q  <= 1'b1;
            end

            case (kbd_state_q)
                KS_IDLE: begin
                    if (!kbddat_i) begin
                        kbd_state_q  <= KS_TX;
                        kbd_bitcnt_q <= '0;
                    end
                end
                KS_WAIT_RX: begin
                    if (kbddat_i && data_valid_q)
                        kbd_state_q <= KS_RX;
                end
                default: ;
            endcase

            // a newly queued key wins over the end-of-byte clear
            if (kbd_in_strobe) begin
                kbd_to_mac_q <= kbd_in_data;
                data_valid_q <= 1'b1;
            end
        end
    end

    assign kbdclk         = kbdclk_q;
    assign kbddata_o      = kbddata_q;
    assign kbd_out_data   = kbd_out_data_q;
    assign kbd_out_strobe = kbd_out_strobe_q;

endmodule

// File: tb/tb_mac_io_glue.sv
`timescale 1ns/1ps
module tb_mac_io_glue;
    localparam logic [19:0] RC  = 20'd40;
    localparam int          KH  = 7;
    localparam int          VPS = 60;

    logic        clk32 = 1'b0;
    logic        _systemReset;
    logic [1:0]  ph = 2'd0;
    logic        clk8_en_p, clk8_en_n;
    logic        _cpuReset;
    logic        _viaIrq, _sccIrq;
    logic [2:0]  _cpuIPL;
    logic        loadSound;
    logic [2:0]  snd_vol;
    logic        snd_ena;
    logic [10:0] audioOut;
    logic        _vblank;
    logic        onesec;
    logic        cb2_o, cb2_t;
    logic        kbdclk, kbddata_o;
    logic [7:0]  kbd_in_data;
    logic        kbd_in_strobe;
    logic [7:0]  kbd_out_data;
    logic        kbd_out_strobe;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_hold  = 16'h0000;

    mac_io_glue_if bus ();

    mac_io_glue #(.RESET_CYCLES(RC), .KBD_HALF(KH), .VBL_PER_SEC(VPS)) dut (
        .clk32          (clk32),
        ._systemReset   (_systemReset),
        .clk8_en_p      (clk8_en_p),
        .clk8_en_n      (clk8_en_n),
        ._cpuReset      (_cpuReset),
        ._viaIrq        (_viaIrq),
        ._sccIrq        (_sccIrq),
        ._cpuIPL        (_cpuIPL),
        .bus            (bus),
        .loadSound      (loadSound),
        .snd_vol        (snd_vol),
        .snd_ena        (snd_ena),
        .audioOut       (audioOut),
        ._vblank        (_vblank),
        .onesec         (onesec),
        .cb2_o          (cb2_o),
        .cb2_t          (cb2_t),
        .kbdclk         (kbdclk),
        .kbddata_o      (kbddata_o),
        .kbd_in_data    (kbd_in_data),
        .kbd_in_strobe  (kbd_in_strobe),
        .kbd_out_data   (kbd_out_data),
        .kbd_out_strobe (kbd_out_strobe)
    );

    always #15 clk32 = ~clk32;
    always @(posedge clk32) ph <= ph + 2'd1;
    assign clk8_en_p = (ph == 2'd0);
    assign clk8_en_n = (ph == 2'd2);

    // Expected audio from the sample value: (sample - 128) times the volume weight.
    function automatic logic [10:0] snd_model(input logic [7:0] s, input logic e, input logic [2:0] v);
        int smp;
        int mult;
        smp = e ? 0 : int'(s) - 128;
`ifdef SND_VOLUME_EN
        mult = int'(v[0]) + 2 * int'(v[1]) + 4 * int'(v[2]);
`else
        mult = (v == v) ? 4 : 4;
`endif
        return 11'(smp * mult);
    endfunction

    task automatic test_reset();
        int   cnt;
        int   budget;
        logic clk_low;
        _systemReset = 1'b0;
        repeat (10) @(negedge clk32);
        n_tests++;
        if (_cpuReset !== 1'b0) begin
            n_fail++; $display("FAIL reset_cpu: _cpuReset=%b want 0", _cpuReset);
        end
        n_tests++;
        if (kbdclk !== 1'b1 || kbddata_o !== 1'b1 || kbd_out_strobe !== 1'b0) begin
            n_fail++; $display("FAIL reset_kbd: kbdclk=%b kbddata_o=%b strobe=%b want 1 1 0", kbdclk, kbddata_o, kbd_out_strobe);
        end
        n_tests++;
        if (audioOut !== 11'd0 || onesec !== 1'b0) begin
            n_fail++; $display("FAIL reset_misc: audioOut=%0d onesec=%b want 0 0", audioOut, onesec);
        end
        n_tests++;
        if (bus.cpuDataOut !== 16'h0000) begin
            n_fail++; $display("FAIL reset_hold: cpuDataOut=%h want 0000", bus.cpuDataOut);
        end
        _systemReset = 1'b1;
        cb2_t = 1'b1; cb2_o = 1'b0;
        cnt = 0; budget = 0; clk_low = 1'b0;
        while (_cpuReset === 1'b0 && budget < 1000) begin
            if (clk8_en_p) cnt++;
            if (kbdclk !== 1'b1) clk_low = 1'b1;
            @(negedge clk32);
            budget++;
        end
        cb2_t = 1'b0; cb2_o = 1'b0;
        n_tests++;
        if (_cpuReset !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: timeout, _cpuReset=%b want 1", _cpuReset);
        end
        n_tests++;
        if (cnt != int'(RC)) begin
            n_fail++; $display("FAIL reset_length: %0d clk8_en_p low, want %0d", cnt, RC);
        end
        n_tests++;
        if (clk_low) begin
            n_fail++; $display("FAIL reset_sync: kbdclk toggled during cpu reset, want held 1");
        end
    endtask

    task automatic test_ipl();
        for (int i = 0; i < 19; i++) begin
            logic       v, s;
            logic [2:0] exp;
            case (i)
                0: begin v = 1'b0; s = 1'b0; end
                1: begin v = 1'b1; s = 1'b0; end
                2: begin v = 1'b1; s = 1'b1; end
                default: begin v = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); end
            endcase
            @(negedge clk32);
            _viaIrq = v; _sccIrq = s;
            #1;
            exp = !v ? 3'b110 : (!s ? 3'b101 : 3'b111);
            n_tests++;
            if (_cpuIPL !== exp) begin
                n_fail++; $display("FAIL ipl[%0d]: via=%b scc=%b ipl=%b want %b", i, v, s, _cpuIPL, exp);
            end
        end
        _viaIrq = 1'b1; _sccIrq = 1'b1;
    endtask

    task automatic test_read_mux();
        for (int i = 0; i < 43; i++) begin
            logic [3:0]  sel;
            logic        cbc, ml;
            logic [15:0] iwm, mem, exp;
            logic [7:0]  via, scc, scsi;
            iwm  = 16'($urandom); mem = 16'($urandom);
            via  = 8'($urandom);  scc = 8'($urandom); scsi = 8'($urandom);
            sel  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            cbc  = 1'($urandom_range(0, 1));
            ml   = 1'($urandom_range(0, 1));
            if (i == 0) begin sel = 4'b0100; scc = 8'h5A; end
            if (i == 1) begin sel = 4'b0000; cbc = 1'b1; ml = 1'b1; mem = 16'h1234; end
            if (i == 2) begin sel = 4'b0000; cbc = 1'b0; ml = 1'b0; end
            @(negedge clk32);
            bus.selectIWM = sel[0]; bus.selectVIA = sel[1];
            bus.selectSCC = sel[2]; bus.selectSCSI = sel[3];
            bus.iwmData = iwm; bus.viaData = via; bus.sccData = scc; bus.scsiData = scsi;
            bus.memoryDataIn = mem; bus.cpuBusControl = cbc; bus.memoryLatch = ml;
            #1;
            if (sel[0])             exp = iwm;
            else if (sel[1])        exp = {via, 8'hEF};
            else if (sel[2])        exp = {scc, 8'hEF};
            else if (sel[3])        exp = {scsi, 8'hEF};
            else if (cbc && ml)     exp = mem;
            else                    exp = m_hold;
            n_tests++;
            if (bus.cpuDataOut !== exp) begin
                n_fail++; $display("FAIL read_mux[%0d]: sel=%b cbc=%b ml=%b cpuDataOut=%h want %h", i, sel, cbc, ml, bus.cpuDataOut, exp);
            end
            if (sel == 4'b0000 && cbc && ml) m_hold = mem;
        end
        @(negedge clk32);
        bus.selectIWM = 1'b0; bus.selectVIA = 1'b0; bus.selectSCC = 1'b0; bus.selectSCSI = 1'b0;
        bus.cpuBusControl = 1'b0; bus.memoryLatch = 1'b0;
    endtask

    task automatic test_audio();
        for (int i = 0; i < 14; i++) begin
            logic [7:0]  s;
            logic        e;
            logic [2:0]  v;
            logic [10:0] exp;
            s = 8'($urandom); e = ($urandom_range(0, 3) == 0); v = 3'($urandom);
            if (i == 0) begin s = 8'hFF; e = 1'b0; v = 3'b111; end
            if (i == 1) begin s = 8'hFF; e = 1'b1; v = 3'b111; end
            if (i == 2) begin s = 8'h00; e = 1'b0; v = 3'b111; end
            @(negedge clk32);
            bus.memoryDataIn = {s, 8'($urandom)};
            snd_ena = e; snd_vol = v;
            loadSound = 1'b1;
            repeat (4) @(negedge clk32);
            loadSound = 1'b0;
            repeat (8) @(negedge clk32);
            exp = snd_model(s, e, v);
            n_tests++;
            if (audioOut !== exp) begin
                n_fail++; $display("FAIL audio[%0d]: s=%h ena=%b vol=%b audioOut=%0d want %0d", i, s, e, v, $signed(audioOut), $signed(exp));
            end
            // sample stays put until the next loadSound; volume applies live
            bus.memoryDataIn = 16'($urandom);
            v = 3'($urandom);
            snd_vol = v;
            repeat (8) @(negedge clk32);
            exp = snd_model(s, e, v);
            n_tests++;
            if (audioOut !== exp) begin
                n_fail++; $display("FAIL audio_hold[%0d]: vol=%b audioOut=%0d want %0d", i, v, $signed(audioOut), $signed(exp));
            end
        end
    endtask

    task automatic test_onesec();
        for (int k = 1; k <= VPS + 1; k++) begin
            logic exp;
            _vblank = 1'b0;
            repeat (8) @(negedge clk32);
            _vblank = 1'b1;
            repeat (8) @(negedge clk32);
            exp = ((k % VPS) == VPS - 1);
            n_tests++;
            if (onesec !== exp) begin
                n_fail++; $display("FAIL onesec[%0d]: onesec=%b want %b", k, onesec, exp);
            end
        end
    endtask

    task automatic kbd_send(input logic [7:0] b);
        int         idx, budget, falls;
        logic       prev, got;
        logic [7:0] cap;
        cb2_t = 1'b1; cb2_o = 1'b0;
        repeat (8) @(negedge clk32);
        cb2_o = b[7]; idx = 7; falls = 0; got = 1'b0; cap = 8'h00; budget = 0;
        prev = kbdclk;
        while (!got && budget < 4000) begin
            @(negedge clk32);
            budget++;
            if (prev && !kbdclk) begin
                falls++;
                if (idx > 0) begin idx--; cb2_o = b[idx]; end
            end
            prev = kbdclk;
            if (kbd_out_strobe === 1'b1) begin got = 1'b1; cap = kbd_out_data; end
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL kbd_tx_timeout: no kbd_out_strobe for %h within %0d cycles", b, budget);
        end
        n_tests++;
        if (cap !== b) begin
            n_fail++; $display("FAIL kbd_tx_data: kbd_out_data=%h want %h", cap, b);
        end
        n_tests++;
        if (falls != 8) begin
            n_fail++; $display("FAIL kbd_tx_clocks: %0d kbdclk falls want 8", falls);
        end
        repeat (4) @(negedge clk32);
        n_tests++;
        if (kbd_out_strobe !== 1'b0) begin
            n_fail++; $display("FAIL kbd_tx_strobe: strobe=%b after one enable, want 0", kbd_out_strobe);
        end
    endtask

    task automatic kbd_recv(input logic [7:0] b);
        int         budget, falls, extra;
        logic       prev, stopped;
        logic [7:0] bits;
        if ($urandom_range(0, 1) == 1) begin cb2_t = 1'b0; cb2_o = 1'($urandom_range(0, 1)); end
        else begin cb2_t = 1'b1; cb2_o = 1'b1; end
        stopped = 1'b1;
        repeat (80) begin
            @(negedge clk32);
            if (kbdclk !== 1'b1) stopped = 1'b0;
        end
        n_tests++;
        if (!stopped) begin
            n_fail++; $display("FAIL kbd_wait_rx: kbdclk ran before a key was queued, want held 1");
        end
        kbd_in_data = b; kbd_in_strobe = 1'b1;
        repeat (4) @(negedge clk32);
        kbd_in_strobe = 1'b0;
        bits = 8'h00; falls = 0; budget = 0; prev = kbdclk;
        while (falls < 8 && budget < 4000) begin
            @(negedge clk32);
            budget++;
            if (prev && !kbdclk) begin
                falls++;
                bits = {bits[6:0], kbddata_o};
            end
            prev = kbdclk;
        end
        extra = 0;
        repeat (200) begin
            @(negedge clk32);
            if (prev && !kbdclk) extra++;
            prev = kbdclk;
        end
        n_tests++;
        if (falls != 8) begin
            n_fail++; $display("FAIL kbd_rx_timeout: %0d bits clocked for %h, want 8", falls, b);
        end
        n_tests++;
        if (bits !== b) begin
            n_fail++; $display("FAIL kbd_rx_data: bits=%b want %b", bits, b);
        end
        n_tests++;
        if (extra != 0 || kbdclk !== 1'b1) begin
            n_fail++; $display("FAIL kbd_rx_stop: extra falls=%0d kbdclk=%b, want 0 and 1", extra, kbdclk);
        end
    endtask

    task automatic test_kbd();
        kbd_send(8'hA5);
        kbd_recv(8'h3C);
        for (int i = 0; i < 2; i++) begin
            kbd_send(8'($urandom));
            kbd_recv(8'($urandom));
        end
    endtask

    initial begin
        _systemReset  = 1'b0;
        _viaIrq       = 1'b1;
        _sccIrq       = 1'b1;
        loadSound     = 1'b0;
        snd_vol       = 3'b000;
        snd_ena       = 1'b0;
        _vblank       = 1'b1;
        cb2_o         = 1'b0;
        cb2_t         = 1'b0;
        kbd_in_data   = 8'h00;
        kbd_in_strobe = 1'b0;
        bus.selectIWM     = 1'b0;
        bus.selectVIA     = 1'b0;
        bus.selectSCC     = 1'b0;
        bus.selectSCSI    = 1'b0;
        bus.iwmData       = 16'h0000;
        bus.viaData       = 8'h00;
        bus.sccData       = 8'h00;
        bus.scsiData      = 8'h00;
        bus.memoryDataIn  = 16'h0000;
        bus.cpuBusControl = 1'b0;
        bus.memoryLatch   = 1'b0;

        test_reset();
        test_ipl();
        test_read_mux();
        test_audio();
        test_onesec();
        test_kbd();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
